fxp64s_shift_arbiter: RTL and testbench

- Shares one combinational fxp64s_var_shifter instance among NUM_REQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on every requester and on the output.
- The shifted result is registered in a single-entry output buffer tagged with the winning requester index.
- Sits between the fxp64s compute lanes (normalisation and scaling requests) and their result consumers.

---
 rtl/fxp64s_shift_arbiter.sv | 130 +++++++++++++
 tb/tb_fxp64s_shift_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fxp64s_shift_arbiter.sv
// Round-robin arbiter sharing one fxp64s variable shifter among NUM_REQ requesters, with a registered result slot.
// Optional: define FXP64S_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.

module fxp64s_var_shifter (
    input  logic [63:0] data_i,
    input  logic [63:0] shift_i,
    output logic [63:0] result_o
);
    logic [5:0] neg_amt;

    always_comb begin
        neg_amt  = 6'd0 - shift_i[5:0];
        result_o = '0;
        if (!shift_i[63]) begin
            if (shift_i[62:6] == '0) result_o = data_i << shift_i[5:0];
        end else if (shift_i[62:6] == '1 && shift_i[5:0] != 6'd0) begin
            // only -1..-63 land here; -64 and below fall through to zero
            result_o = $signed(data_i) >>> neg_amt;
        end
    end
endmodule

module fxp64s_shift_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_data,
    input  logic [NUM_REQ*64-1:0] req_shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_data,
    output logic [ID_W-1:0]       out_id
);
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $fatal(1, "ID_W must equal clog2(NUM_REQ)");
    end

`ifdef FXP64S_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ-1);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [63:0]     out_data_q, out_data_d;
    logic [ID_W-1:0] out_id_q, out_id_d;

    logic            found;
    logic [ID_W-1:0] grant;
    logic            slot_free;
    logic            hs;
    logic [63:0]     sel_data, sel_shift, shift_result;

    always_comb begin
        logic [ID_W:0]   cand_sum;
        logic [ID_W-1:0] cand;
        found    = 1'b0;
        grant    = '0;
        cand_sum = '0;
        cand     = '0;
        if (PRIO_EN && req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
                cand = cand_sum[ID_W-1:0];
                if (!found && req_valid[cand] && !(PRIO_EN && cand == '0)) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    assign slot_free = ~out_valid_q | out_ready;
    assign hs        = rstn & slot_free & found;
    assign req_ready = hs ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;

    assign sel_data  = req_data[{grant, 6'b0} +: 64];
    assign sel_shift = req_shift[{grant, 6'b0} +: 64];

    fxp64s_var_shifter u_shifter (
        .data_i   (sel_data),
        .shift_i  (sel_shift),
        .result_o (shift_result)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (hs) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_result;
            out_id_d    = grant;
            // requester 0 sits outside the rotation when it has priority
            if (!(PRIO_EN && grant == '0)) rr_ptr_d = (grant == LAST_ID) ? '0 : grant + ID_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
endmodule

// File: tb/tb_fxp64s_shift_arbiter.sv
// Directed bench for fxp64s_shift_arbiter in the default round-robin build.
module tb_fxp64s_shift_arbiter;
    logic          clk = 1'b0;
    logic          rstn;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [255:0]  req_data;
    logic [255:0]  req_shift;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [1:0]    out_id;

    int checks = 0;
    int errors = 0;

    fxp64s_shift_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // single requester transfer, then drain the slot with out_ready held high
    task automatic do_one(input int idx, input logic [63:0] d, input logic [63:0] s,
                          input logic [63:0] exp, input string tag);
        req_valid = 4'b0001 << idx;
        req_data[idx*64 +: 64]  = d;
        req_shift[idx*64 +: 64] = s;
        #2;
        chk({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << idx));
        tick();
        req_valid = 4'b0000;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_id"}, 64'(out_id), 64'(idx));
        tick();
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] rr_val [4];
        for (int i = 0; i < 4; i++) rr_val[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);

        rstn      = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_data  = '0;
        req_shift = '0;
        for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = 64'(i + 1);
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);

        rstn = 1'b1;
        #2;
        chk("first_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0000;
        chk("first_id", 64'(out_id), 64'd0);
        chk("first_data", out_data, 64'd1);
        tick();
        chk("first_drain", 64'(out_valid), 64'd0);

        // rr_ptr now 1, and each single transfer below advances it by one
        do_one(1, 64'h0001_0000_0000_0000, 64'd1, 64'h0002_0000_0000_0000, "lsh1");
        do_one(2, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hC000_8000_0000_0000, "rsh1");
        do_one(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd64, 64'd0, "sat_p64");
        do_one(0, 64'h7FFF_FFFF_FFFF_FFFF, -64'sd70, 64'd0, "sat_m70");
        do_one(1, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'hDEAD_BEEF_0123_4567, "pass0");
        do_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, "sat_min");
        do_one(3, 64'd1, 64'd63, 64'h8000_0000_0000_0000, "lsh63");
        do_one(0, 64'h8000_0000_0000_0000, -64'sd63, 64'hFFFF_FFFF_FFFF_FFFF, "rsh63");
        do_one(1, 64'h8000_0000_0000_0000, -64'sd64, 64'd0, "sat_m64");

        // fresh reset so the rotation starts at requester 0
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_data[i*64 +: 64]  = rr_val[i];
            req_shift[i*64 +: 64] = 64'd0;
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("rr_valid", 64'(out_valid), 64'd1);
            chk("rr_id", 64'(out_id), 64'(n % 4));
            chk("rr_data", out_data, rr_val[n % 4]);
        end

        // slot holds requester 3's result; stall with requesters 1 and 3 pending
        out_ready = 1'b0;
        req_valid = 4'b1010;
        for (int n = 0; n < 5; n++) begin
            #2;
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_id", 64'(out_id), 64'd3);
            chk("bp_data", out_data, rr_val[3]);
        end
        out_ready = 1'b1;
        #2;
        chk("bp_rel_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1000;
        chk("bp_rel_valid", 64'(out_valid), 64'd1);
        chk("bp_rel_id", 64'(out_id), 64'd1);
        chk("bp_rel_data", out_data, rr_val[1]);
        #1;
        chk("bp_next_ready", 64'(req_ready), 64'b1000);
        tick();
        req_valid = 4'b0000;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_id", 64'(out_id), 64'd3);
        chk("bp_next_data", out_data, rr_val[3]);
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);
        chk("idle_data_hold", out_data, rr_val[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
